// File: rtl/mod7_seq_checker.sv
// mod7_seq_checker: lock/slip monitor for a mod-7 counter stream with error and wrap reporting
module mod7_seq_checker #(
    parameter int LOCK_CNT   = 3,
    parameter int MISS_LIMIT = 2,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             in_valid,
    input  logic [2:0]       count_in,
    input  logic             clr_err,
    output logic             locked,
    output logic             err_pulse,
    output logic             wrap_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [2:0]       expected
);
    typedef enum logic [1:0] {HUNT, LOCKED, SLIP} state_t;
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(MISS_LIMIT + 1);
    state_t state, state_n;
    logic [2:0] prev, prev_n;
    logic [GW-1:0] good_run, good_run_n;
    logic [BW-1:0] bad_run, bad_run_n;
    logic [ERR_W-1:0] err_count_n;
    logic err_pulse_n, wrap_pulse_n, inc, match;
    function automatic logic [2:0] nxt(input logic [2:0] c);
        return (c >= 3'd6) ? 3'd0 : c + 3'd1;
    endfunction
    assign expected = nxt(prev);
    assign match = count_in == expected;
    assign locked = state != HUNT;
    always_comb begin
        state_n = state;
        prev_n = prev;
        good_run_n = good_run;
        bad_run_n = bad_run;
        err_pulse_n = 1'b0;
        wrap_pulse_n = 1'b0;
        inc = 1'b0;
        if (in_valid) begin
            prev_n = count_in;
            wrap_pulse_n = locked && match && prev == 3'd6;
            case (state)
                HUNT: begin
                    good_run_n = match ? good_run + 1'b1 : '0;
                    if (match && 32'(good_run) + 1 >= LOCK_CNT) begin
                        state_n = LOCKED;
                        good_run_n = '0;
                    end
                end
                LOCKED: if (!match) begin
                    inc = 1'b1;
                    err_pulse_n = 1'b1;
                    state_n = (MISS_LIMIT == 1) ? HUNT : SLIP;
                    bad_run_n = (MISS_LIMIT == 1) ? '0 : BW'(1);
                end
                SLIP: begin
                    inc = !match;
                    err_pulse_n = !match;
                    state_n = match ? LOCKED : state;
                    bad_run_n = match ? '0 : bad_run + 1'b1;
                    if (!match && 32'(bad_run) + 1 >= MISS_LIMIT) begin
                        state_n = HUNT;
                        bad_run_n = '0;
                    end
                end
                default: state_n = HUNT;
            endcase
        end
        // saturate at all-ones; a clear coinciding with a new error leaves exactly that error
        err_count_n = clr_err ? ERR_W'(inc) : err_count + ERR_W'(inc && !(&err_count));
    end
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state <= HUNT;
            prev <= 3'b111;
            good_run <= '0;
            bad_run <= '0;
            err_pulse <= 1'b0;
            wrap_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            state <= state_n;
            prev <= prev_n;
            good_run <= good_run_n;
            bad_run <= bad_run_n;
            err_pulse <= err_pulse_n;
            wrap_pulse <= wrap_pulse_n;
            err_count <= err_count_n;
        end
    end
endmodule
